kgp_ctrl_fsm: RTL and testbench

Multi-cycle control sequencer for the KGP-RISC core. Sits between the instruction decoder and the datapath: it drives the instruction-fetch handshake, samples `opCode`/`functCode` from the decoder once per instruction, and steps the register file, ALU, data memory and PC through FETCH → DECODE → EXEC → MEM → WB. It also keeps a retired-instruction counter and flags illegal encodings.

---
 rtl/kgp_ctrl_fsm.sv | 272 +++++++++++++++++++++++++++
 tb/tb_kgp_ctrl_fsm.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kgp_ctrl_fsm.sv
// kgp_ctrl_fsm: multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the KGP-RISC core.
// Optional feature: define KGP_CTRL_TIMEOUT_EN to fault to ERR after TIMEOUT_CYCLES of memory wait.
module kgp_ctrl_fsm #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic [2:0]  opCode,
    input  logic [3:0]  functCode,
    input  logic        flag_z,
    input  logic        flag_c,
    input  logic        flag_s,
    output logic        imem_req,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic [3:0]  alu_op,
    output logic        alu_src_imm,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        link_r31,
    output logic        busy,
    output logic        illegal,
    output logic [2:0]  state_o,
    output logic [31:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    localparam logic [2:0] OP_ALU_R   = 3'b000;
    localparam logic [2:0] OP_ALU_I   = 3'b001;
    localparam logic [2:0] OP_LOAD    = 3'b010;
    localparam logic [2:0] OP_STORE   = 3'b011;
    localparam logic [2:0] OP_BR_REG  = 3'b100;
    localparam logic [2:0] OP_BR_LBL  = 3'b101;
    localparam logic [2:0] OP_SHIFT_I = 3'b110;
    localparam logic [2:0] OP_SYS     = 3'b111;

    localparam logic [3:0] FN_NOP  = 4'b0000;
    localparam logic [3:0] FN_LINK = 4'b0001;
    localparam logic [3:0] FN_HALT = 4'b1111;

    localparam logic [1:0] PC_SEQ   = 2'd0;
    localparam logic [1:0] PC_LABEL = 2'd1;
    localparam logic [1:0] PC_REG   = 2'd2;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_MEM  = 2'd1;
    localparam logic [1:0] WB_LINK = 2'd2;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("kgp_ctrl_fsm: TIMEOUT_CYCLES must be at least 2");
    end

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [3:0]  fn_q, fn_d;
    logic        illegal_q, illegal_d;
    logic [31:0] count_q;
    logic        retire;
    logic        timeout;

    function automatic logic encoding_legal(input logic [2:0] op, input logic [3:0] fn);
        case (op)
            OP_BR_REG: encoding_legal = (fn == 4'b0000);
            OP_BR_LBL: encoding_legal = (fn[3] == 1'b0);
            OP_SYS:    encoding_legal = (fn == FN_NOP) || (fn == FN_HALT);
            default:   encoding_legal = 1'b1;
        endcase
    endfunction

    // Low three funct bits select the condition; 000 and 001 (link) are unconditional.
    function automatic logic label_taken(input logic [3:0] fn, input logic z, input logic c,
                                         input logic s);
        case (fn[2:0])
            3'd0, 3'd1: label_taken = 1'b1;
            3'd2:       label_taken = c;
            3'd3:       label_taken = !c;
            3'd4:       label_taken = z;
            3'd5:       label_taken = !z;
            3'd6:       label_taken = s;
            default:    label_taken = !s;
        endcase
    endfunction

`ifdef KGP_CTRL_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WAIT_W-1:0] wait_q, wait_d;

    // Cleared whenever the ready arrives or the state is left, so each FETCH/MEM visit starts at 0.
    always_comb begin
        wait_d = '0;
        if ((state_q == S_FETCH && !imem_ready) || (state_q == S_MEM && !dmem_ready)) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    assign timeout = (wait_d == WAIT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        // NOTE: every next-state and output gets a default first, so no path through the case infers a latch.
        state_d     = state_q;
        op_d        = op_q;
        fn_d        = fn_q;
        illegal_d   = illegal_q;
        retire      = 1'b0;
        imem_req    = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_src      = PC_SEQ;
        alu_op      = 4'd0;
        alu_src_imm = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        reg_we      = 1'b0;
        wb_sel      = WB_ALU;
        link_r31    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end

            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    pc_src  = PC_SEQ;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d   = S_ERR;
                    illegal_d = 1'b1;
                end
            end

            S_DECODE: begin
                op_d = opCode;
                fn_d = functCode;
                if (!encoding_legal(opCode, functCode)) begin
                    state_d   = S_ERR;
                    illegal_d = 1'b1;
                end else if (opCode == OP_SYS) begin
                    retire  = 1'b1;
                    state_d = (functCode == FN_HALT) ? S_HALT : S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                alu_op = fn_q;
                unique case (op_q)
                    OP_ALU_R: state_d = S_WB;
                    OP_ALU_I, OP_SHIFT_I: begin
                        alu_src_imm = 1'b1;
                        state_d     = S_WB;
                    end
                    OP_LOAD: begin
                        alu_src_imm = 1'b1;
                        state_d     = S_MEM;
                    end
                    OP_STORE: state_d = S_MEM;
                    OP_BR_REG: begin
                        pc_we   = 1'b1;
                        pc_src  = PC_REG;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    OP_BR_LBL: begin
                        if (label_taken(fn_q, flag_z, flag_c, flag_s)) begin
                            pc_we  = 1'b1;
                            pc_src = PC_LABEL;
                        end
                        if (fn_q == FN_LINK) begin
                            state_d = S_WB;
                        end else begin
                            retire  = 1'b1;
                            state_d = S_FETCH;
                        end
                    end
                    default: begin
                        // The system group never dispatches to EXEC; treat arrival here as a fault.
                        state_d   = S_ERR;
                        illegal_d = 1'b1;
                    end
                endcase
            end

            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (op_q == OP_STORE);
                if (dmem_ready) begin
                    if (op_q == OP_STORE) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout) begin
                    state_d   = S_ERR;
                    illegal_d = 1'b1;
                end
            end

            S_WB: begin
                reg_we = 1'b1;
                if (op_q == OP_LOAD) begin
                    wb_sel = WB_MEM;
                end else if (op_q == OP_BR_LBL) begin
                    wb_sel   = WB_LINK;
                    link_r31 = 1'b1;
                end
                retire  = 1'b1;
                state_d = S_FETCH;
            end

            S_HALT, S_ERR: begin
                state_d = state_q;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= 3'd0;
            fn_q      <= 4'd0;
            illegal_q <= 1'b0;
            count_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            fn_q      <= fn_d;
            illegal_q <= illegal_d;
            if (retire) count_q <= count_q + 32'd1;
        end
    end

    assign busy        = state_q inside {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB};
    assign illegal     = illegal_q;
    assign state_o     = state_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_kgp_ctrl_fsm.sv
// Self-checking bench for kgp_ctrl_fsm: directed test-plan scenarios plus a random instruction
// stream, each instruction scored against a behavioural per-instruction model.
module tb_kgp_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        imem_ready;
    logic        dmem_ready;
    logic [2:0]  opCode;
    logic [3:0]  functCode;
    logic        flag_z, flag_c, flag_s;
    logic        imem_req, ir_we, pc_we, alu_src_imm, dmem_req, dmem_we, reg_we;
    logic        link_r31, busy, illegal;
    logic [1:0]  pc_src, wb_sel;
    logic [3:0]  alu_op;
    logic [2:0]  state_o;
    logic [31:0] instr_count;
    logic [52:0] outs;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] exp_count;
    logic        exp_illegal;
    int          trace_q[$];

    kgp_ctrl_fsm #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .start(start), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .opCode(opCode), .functCode(functCode), .flag_z(flag_z), .flag_c(flag_c), .flag_s(flag_s),
        .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_op(alu_op),
        .alu_src_imm(alu_src_imm), .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_we(reg_we),
        .wb_sel(wb_sel), .link_r31(link_r31), .busy(busy), .illegal(illegal),
        .state_o(state_o), .instr_count(instr_count)
    );

    assign outs = {imem_req, ir_we, pc_we, pc_src, alu_op, alu_src_imm, dmem_req, dmem_we,
                   reg_we, wb_sel, link_r31, busy, illegal, state_o, instr_count};

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests_run);
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        #3;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_count   = 32'd0;
        exp_illegal = 1'b0;
    endtask

    task automatic go();
        imem_ready = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        tests_run++;
        if (state_o !== 3'd1) begin
            tests_failed++;
            $display("FAIL start_to_fetch: state got %0d expected 1", state_o);
        end
    endtask

    // Runs one instruction from FETCH and compares its observed behaviour with the model.
    task automatic run_instr(input string tag, input logic [2:0] op, input logic [3:0] fn,
                             input int iw, input int dw, input logic fz, input logic fc,
                             input logic fs);
        bit legal, taken, link, is_alu, is_load, is_store, exp_exec, exp_imm;
        int exp_lat, exp_end, exp_pcwe, exp_src, exp_regwe, exp_wbsel, exp_dreq, exp_dwe;
        int cyc, fcnt, mcnt, s;
        int o_imem, o_irwe, o_pcwe, o_src, o_regwe, o_wbsel, o_link, o_dreq, o_dwe;
        int o_nobusy, o_alu_other, o_alu_exec, o_imm;
        bit left_fetch, done, hung;

        legal = 1'b1; taken = 1'b0; link = 1'b0; exp_end = 1;
        is_alu   = (op == 3'd0) || (op == 3'd1) || (op == 3'd6);
        is_load  = (op == 3'd2);
        is_store = (op == 3'd3);
        case (op)
            3'd4: begin legal = (fn == 4'd0); taken = legal; end
            3'd5: begin
                legal = (fn < 4'd8);
                link  = (fn == 4'd1);
                case (fn)
                    4'd0, 4'd1: taken = 1'b1;
                    4'd2:       taken = fc;
                    4'd3:       taken = !fc;
                    4'd4:       taken = fz;
                    4'd5:       taken = !fz;
                    4'd6:       taken = fs;
                    4'd7:       taken = !fs;
                    default:    taken = 1'b0;
                endcase
            end
            3'd7: begin
                legal = (fn == 4'd0) || (fn == 4'd15);
                if (fn == 4'd15) exp_end = 6;
            end
            default: ;
        endcase
        if (!legal) exp_end = 7;
        exp_exec  = legal && (op != 3'd7);
        exp_lat   = iw + (!exp_exec ? 2 : is_load ? 5 + dw : is_store ? 4 + dw :
                          (is_alu || link) ? 4 : 3);
        exp_pcwe  = taken ? 2 : 1;
        exp_src   = taken ? ((op == 3'd4) ? 2 : 1) : 0;
        exp_regwe = (is_alu || is_load || link) ? 1 : 0;
        exp_wbsel = is_load ? 1 : link ? 2 : 0;
        exp_dreq  = (is_load || is_store) ? dw + 1 : 0;
        exp_dwe   = is_store ? dw + 1 : 0;
        exp_imm   = (op == 3'd1) || (op == 3'd6) || (op == 3'd2);

        opCode = op; functCode = fn; flag_z = fz; flag_c = fc; flag_s = fs;
        cyc = 0; fcnt = 0; mcnt = 0; left_fetch = 1'b0; done = 1'b0; hung = 1'b0;
        o_imem = 0; o_irwe = 0; o_pcwe = 0; o_src = 0; o_regwe = 0; o_wbsel = 0; o_link = 0;
        o_dreq = 0; o_dwe = 0; o_nobusy = 0; o_alu_other = 0; o_alu_exec = -1; o_imm = -1;
        trace_q.delete();

        while (!done) begin
            s = int'(state_o);
            trace_q.push_back(s);
            imem_ready = 1'b0;
            dmem_ready = 1'b0;
            if (s == 1) begin imem_ready = (fcnt >= iw); fcnt++; end
            else left_fetch = 1'b1;
            if (s == 4) begin dmem_ready = (mcnt >= dw); mcnt++; end
            @(negedge clk);
            if (imem_req) o_imem++;
            if (ir_we)    o_irwe++;
            if (pc_we)    begin o_pcwe++; o_src = int'(pc_src); end
            if (reg_we)   begin o_regwe++; o_wbsel = int'(wb_sel); o_link = int'(link_r31); end
            if (dmem_req) o_dreq++;
            if (dmem_we)  o_dwe++;
            if (!busy)    o_nobusy++;
            if (s == 3) begin o_alu_exec = int'(alu_op); o_imm = int'(alu_src_imm); end
            else if (alu_op != 4'd0) o_alu_other++;
            @(posedge clk); #1;
            cyc++;
            s = int'(state_o);
            if ((s == 1 && left_fetch) || s == 0 || s == 6 || s == 7) done = 1'b1;
            else if (cyc >= 200) begin done = 1'b1; hung = 1'b1; end
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;

        tests_run++;
        if (hung) begin
            tests_failed++;
            $display("FAIL %s bounded_wait: got %0d cycles without completion, required %0d",
                     tag, cyc, exp_lat);
            return;
        end
        if (legal) exp_count = exp_count + 32'd1;
        if (!legal) exp_illegal = 1'b1;

        if (cyc !== exp_lat) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d expected %0d", tag, cyc, exp_lat);
        end
        tests_run++;
        if (int'(state_o) !== exp_end) begin
            tests_failed++;
            $display("FAIL %s end_state: got %0d expected %0d", tag, state_o, exp_end);
        end
        tests_run++;
        if (o_imem !== iw + 1 || o_irwe !== 1) begin
            tests_failed++;
            $display("FAIL %s fetch: imem_req %0d ir_we %0d expected %0d and 1",
                     tag, o_imem, o_irwe, iw + 1);
        end
        tests_run++;
        if (o_pcwe !== exp_pcwe || o_src !== exp_src) begin
            tests_failed++;
            $display("FAIL %s pc_write: count %0d src %0d expected %0d src %0d",
                     tag, o_pcwe, o_src, exp_pcwe, exp_src);
        end
        tests_run++;
        if (o_regwe !== exp_regwe) begin
            tests_failed++;
            $display("FAIL %s reg_we: got %0d cycles expected %0d", tag, o_regwe, exp_regwe);
        end
        if (exp_regwe == 1) begin
            tests_run++;
            if (o_wbsel !== exp_wbsel || o_link !== int'(link)) begin
                tests_failed++;
                $display("FAIL %s writeback: wb_sel %0d link %0d expected %0d link %0d",
                         tag, o_wbsel, o_link, exp_wbsel, link);
            end
        end
        tests_run++;
        if (o_dreq !== exp_dreq || o_dwe !== exp_dwe) begin
            tests_failed++;
            $display("FAIL %s dmem: req %0d we %0d expected %0d we %0d",
                     tag, o_dreq, o_dwe, exp_dreq, exp_dwe);
        end
        if (exp_exec) begin
            tests_run++;
            if (o_alu_exec !== int'(fn) || o_imm !== int'(exp_imm)) begin
                tests_failed++;
                $display("FAIL %s exec: alu_op %0d imm %0d expected %0d imm %0d",
                         tag, o_alu_exec, o_imm, fn, exp_imm);
            end
        end
        tests_run++;
        if (o_alu_other !== 0 || o_nobusy !== 0) begin
            tests_failed++;
            $display("FAIL %s idle_outputs: alu_op outside EXEC %0d, busy low %0d, expected 0 0",
                     tag, o_alu_other, o_nobusy);
        end
        tests_run++;
        if (instr_count !== exp_count || illegal !== exp_illegal) begin
            tests_failed++;
            $display("FAIL %s count_illegal: count %0d illegal %0b expected %0d %0b",
                     tag, instr_count, illegal, exp_count, exp_illegal);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        opCode = 3'd0; functCode = 4'd0; flag_z = 1'b0; flag_c = 1'b0; flag_s = 1'b0;
        exp_count = 32'd0; exp_illegal = 1'b0;
        #2;
        tests_run++;
        if (outs !== 53'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        imem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (outs !== 53'd0) begin
            tests_failed++;
            $display("FAIL idle_without_start: got %h expected 0", outs);
        end
        go();
        @(negedge clk);
        tests_run++;
        if (imem_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL fetch_request: imem_req got %0b expected 1", imem_req);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (outs !== 53'd0) begin
            tests_failed++;
            $display("FAIL async_reset: got %h expected 0", outs);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_alu();
        logic [31:0] ir;
        int exp_tr[$];
        do_reset();
        go();
        ir = 32'h0A1DCD73;
        run_instr("alu_vec", ir[31:29], ir[3:0], 0, 0, 1'b0, 1'b0, 1'b0);
        exp_tr = '{1, 2, 3, 5};
        tests_run++;
        if (trace_q != exp_tr || instr_count !== 32'd1) begin
            tests_failed++;
            $display("FAIL alu_sequence: trace %p count %0d expected %p count 1",
                     trace_q, instr_count, exp_tr);
        end
    endtask

    task automatic test_load_wait();
        run_instr("load_wait3", 3'd2, 4'd5, 0, 3, 1'b0, 1'b0, 1'b0);
        run_instr("store_wait2", 3'd3, 4'd9, 1, 2, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_branch_z();
        run_instr("bz_taken", 3'd5, 4'd4, 0, 0, 1'b1, 1'b0, 1'b0);
        run_instr("bz_not_taken", 3'd5, 4'd4, 0, 0, 1'b0, 1'b1, 1'b1);
        run_instr("br_reg", 3'd4, 4'd0, 2, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_instr("b2b_addi", 3'd1, 4'd2, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr("b2b_link", 3'd5, 4'd1, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr("b2b_nop", 3'd7, 4'd0, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr("b2b_shift", 3'd6, 4'd7, 1, 0, 1'b0, 1'b0, 1'b0);
        run_instr("b2b_store", 3'd3, 4'd0, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr("b2b_bnc", 3'd5, 4'd3, 0, 0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_illegal();
        logic [31:0] cnt_before;
        cnt_before = instr_count;
        run_instr("illegal_sys", 3'd7, 4'd3, 0, 0, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        tests_run++;
        if (state_o !== 3'd7 || illegal !== 1'b1 || busy !== 1'b0 || instr_count !== cnt_before) begin
            tests_failed++;
            $display("FAIL err_hold: state %0d illegal %0b busy %0b count %0d expected 7 1 0 %0d",
                     state_o, illegal, busy, instr_count, cnt_before);
        end
        #3;
        rst = 1'b1;
        #1;
        tests_run++;
        if (outs !== 53'd0) begin
            tests_failed++;
            $display("FAIL reset_from_err: got %h expected 0", outs);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_count = 32'd0;
        exp_illegal = 1'b0;
    endtask

    task automatic test_halt();
        go();
        run_instr("pre_halt_nop", 3'd7, 4'd0, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr("halt", 3'd7, 4'd15, 1, 0, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b0;
        tests_run++;
        if (state_o !== 3'd6 || instr_count !== 32'd2 || busy !== 1'b0 || imem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL halt_hold: state %0d count %0d busy %0b req %0b expected 6 2 0 0",
                     state_o, instr_count, busy, imem_req);
        end
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        go();
        n = 0;
        while (state_o == 3'd1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        tests_run++;
`ifdef KGP_CTRL_TIMEOUT_EN
        if (n !== 16 || state_o !== 3'd7 || illegal !== 1'b1 || imem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL fetch_timeout: cycles %0d state %0d illegal %0b req %0b expected 16 7 1 0",
                     n, state_o, illegal, imem_req);
        end
`else
        if (n !== 100 || state_o !== 3'd1 || imem_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL unbounded_wait: cycles %0d state %0d req %0b expected 100 1 1",
                     n, state_o, imem_req);
        end
`endif
    endtask

    task automatic test_random();
        logic [2:0] op;
        logic [3:0] fn;
        do_reset();
        go();
        for (int i = 0; i < 80; i++) begin
            op = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) begin
                fn = 4'($urandom_range(0, 15));
            end else begin
                case (op)
                    3'd4:    fn = 4'd0;
                    3'd5:    fn = 4'($urandom_range(0, 7));
                    3'd7:    fn = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'd0;
                    default: fn = 4'($urandom_range(0, 15));
                endcase
            end
            run_instr("random", op, fn, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
            if (state_o !== 3'd1) begin
                do_reset();
                go();
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_wait();
        test_branch_z();
        test_back_to_back();
        test_illegal();
        test_halt();
        test_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
